// File: rtl/stencil_3d_sequencer.sv
// Sequences one plane sweep through the laplace_3d datapath: fetches column words from the
// input buffer, feeds them to the datapath, and tracks results through its fixed latency.
module stencil_3d_sequencer #(
  parameter int unsigned BW       = 32,
  parameter int unsigned ST       = 3,
  parameter int unsigned MAX_COLS = 64,
  parameter int unsigned AW       = 6,
  parameter int unsigned PIPE_LAT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic [AW:0]          io_num_cols,
  input  logic                 io_stall,
  output logic                 io_mem_rd_en,
  output logic [AW-1:0]        io_mem_rd_addr,
  input  logic [BW*ST*ST-1:0]  io_mem_rd_data,
  output logic                 io_datapath_ready_in,
  output logic [BW*ST*ST-1:0]  io_datapath_data_in,
  output logic                 io_out_valid,
  output logic [AW-1:0]        io_out_index,
  output logic                 io_busy,
  output logic                 io_done
);

  localparam logic [AW:0]   MaxCols = (AW + 1)'(MAX_COLS);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] IdxOne  = AW'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                state_q;
  logic [AW:0]           count_q;
  logic [AW:0]           issued_q;
  logic                  rd_en_q;
  logic [AW-1:0]         rd_addr_q;
  logic                  ready_q;
  logic [PIPE_LAT-1:0]   pipe_q;
  logic [AW-1:0]         index_q;

  logic [AW:0]           num_clamped;
  logic                  can_issue;
  logic                  last_out;

  // Clamp the requested count and decode issue / final-result conditions.
  always_comb begin
    num_clamped = (io_num_cols > MaxCols) ? MaxCols : io_num_cols;
    can_issue   = !io_stall && (issued_q < count_q);
    last_out    = pipe_q[PIPE_LAT-1] && ({1'b0, index_q} == (count_q - CntOne));
  end

  // Sweep FSM; the read strobe is registered, so stall is folded into the issue decision
  // made on the edge that opens the read cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      issued_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ready_q   <= 1'b0;
      index_q   <= '0;
    end else begin
      ready_q <= rd_en_q;
      if (pipe_q[PIPE_LAT-1]) index_q <= index_q + IdxOne;
      unique case (state_q)
        StIdle: begin
          rd_en_q <= 1'b0;
          if (io_start) begin
            if (num_clamped == '0) begin
              state_q <= StDone;
            end else begin
              count_q   <= num_clamped;
              index_q   <= '0;
              rd_addr_q <= '0;
              rd_en_q   <= !io_stall;
              issued_q  <= io_stall ? '0 : CntOne;
              state_q   <= (!io_stall && num_clamped == CntOne) ? StDrain : StFetch;
            end
          end
        end
        StFetch: begin
          if (can_issue) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= issued_q[AW-1:0];
            issued_q  <= issued_q + CntOne;
            if (issued_q + CntOne == count_q) state_q <= StDrain;
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        StDrain: begin
          rd_en_q <= 1'b0;
          if (last_out) state_q <= StDone;
        end
        StDone: begin
          rd_en_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Latency tracker: one bit per datapath stage, fed by ready_in.
  if (PIPE_LAT == 1) begin : g_pipe_one
    always_ff @(posedge clock or posedge reset) begin
      if (reset) pipe_q <= '0;
      else       pipe_q <= ready_q;
    end
  end else begin : g_pipe_multi
    always_ff @(posedge clock or posedge reset) begin
      if (reset) pipe_q <= '0;
      else       pipe_q <= {pipe_q[PIPE_LAT-2:0], ready_q};
    end
  end

  // Output drive; data_in is gated so the datapath sees zero between columns.
  always_comb begin
    io_mem_rd_en         = rd_en_q;
    io_mem_rd_addr       = rd_addr_q;
    io_datapath_ready_in = ready_q;
    io_datapath_data_in  = ready_q ? io_mem_rd_data : '0;
    io_out_valid         = pipe_q[PIPE_LAT-1];
    io_out_index         = index_q;
    io_busy              = (state_q != StIdle);
    io_done              = (state_q == StDone);
  end

endmodule

// File: tb/tb_stencil_3d_sequencer.sv
// Directed bench for stencil_3d_sequencer: logs every output event per sweep cycle and
// compares against hand-derived cycle/address/index expectations.
module tb_stencil_3d_sequencer;

  localparam int unsigned BW       = 32;
  localparam int unsigned ST       = 3;
  localparam int unsigned MAX_COLS = 64;
  localparam int unsigned AW       = 6;
  localparam int unsigned PIPE_LAT = 8;
  localparam int unsigned DW       = BW * ST * ST;

  typedef logic [DW-1:0] word_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_start;
  logic [AW:0]   io_num_cols;
  logic          io_stall;
  logic          io_mem_rd_en;
  logic [AW-1:0] io_mem_rd_addr;
  word_t         io_mem_rd_data;
  logic          io_datapath_ready_in;
  word_t         io_datapath_data_in;
  logic          io_out_valid;
  logic [AW-1:0] io_out_index;
  logic          io_busy;
  logic          io_done;

  stencil_3d_sequencer #(
    .BW       (BW),
    .ST       (ST),
    .MAX_COLS (MAX_COLS),
    .AW       (AW),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .io_start             (io_start),
    .io_num_cols          (io_num_cols),
    .io_stall             (io_stall),
    .io_mem_rd_en         (io_mem_rd_en),
    .io_mem_rd_addr       (io_mem_rd_addr),
    .io_mem_rd_data       (io_mem_rd_data),
    .io_datapath_ready_in (io_datapath_ready_in),
    .io_datapath_data_in  (io_datapath_data_in),
    .io_out_valid         (io_out_valid),
    .io_out_index         (io_out_index),
    .io_busy              (io_busy),
    .io_done              (io_done)
  );

  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  int c_prev = 0;
  bit logging = 1'b0;

  int    rd_cyc[$];
  int    rd_adr[$];
  int    rdy_cyc[$];
  word_t rdy_dat[$];
  int    ov_cyc[$];
  int    ov_idx[$];
  int    done_cyc[$];
  int    busy_n;
  int    busy_first;

  function automatic word_t mem_word(input int i);
    return {(ST * ST){32'hC0DE_0000 | 32'(i)}};
  endfunction

  // Buffer model: registered read, data valid the cycle after rd_en.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (io_mem_rd_en) io_mem_rd_data <= mem_word(int'(io_mem_rd_addr));
  end

  // Event log, sampled mid-cycle; times are relative to the start-sample cycle.
  always @(negedge clock) begin
    if (logging) begin
      if (io_mem_rd_en) begin
        rd_cyc.push_back(cyc - c0);
        rd_adr.push_back(int'(io_mem_rd_addr));
      end
      if (io_datapath_ready_in) begin
        rdy_cyc.push_back(cyc - c0);
        rdy_dat.push_back(io_datapath_data_in);
      end
      if (io_out_valid) begin
        ov_cyc.push_back(cyc - c0);
        ov_idx.push_back(int'(io_out_index));
      end
      if (io_done) done_cyc.push_back(cyc - c0);
      if (io_busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = cyc - c0;
      end
    end
  end

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_cyc.delete();
    rd_adr.delete();
    rdy_cyc.delete();
    rdy_dat.delete();
    ov_cyc.delete();
    ov_idx.delete();
    done_cyc.delete();
    busy_n = 0;
    busy_first = -1;
  endtask

  // Called at a negedge; that cycle becomes cycle 0.
  task automatic start_sweep(input int n);
    clear_log();
    c0 = cyc;
    logging = 1'b1;
    io_start = 1'b1;
    io_num_cols = (AW + 1)'(n);
    @(negedge clock);
    io_start = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - c0 < r) @(negedge clock);
  endtask

  // Reads land in cycles i+1, shifted by gap_len from read gap_at onward.
  task automatic check_sweep(input string tag, input int n, input int gap_at,
                             input int gap_len, input int exp_done);
    int e;
    check_eq({tag, ".rd_n"}, word_t'(rd_cyc.size()), word_t'(n));
    check_eq({tag, ".rdy_n"}, word_t'(rdy_cyc.size()), word_t'(n));
    check_eq({tag, ".ov_n"}, word_t'(ov_cyc.size()), word_t'(n));
    for (int i = 0; i < n; i++) begin
      e = i + 1 + ((i >= gap_at) ? gap_len : 0);
      if (i < rd_cyc.size()) begin
        check_eq($sformatf("%s.rd_cyc%0d", tag, i), word_t'(rd_cyc[i]), word_t'(e));
        check_eq($sformatf("%s.rd_adr%0d", tag, i), word_t'(rd_adr[i]), word_t'(i));
      end
      if (i < rdy_cyc.size()) begin
        check_eq($sformatf("%s.rdy_cyc%0d", tag, i), word_t'(rdy_cyc[i]), word_t'(e + 1));
        check_eq($sformatf("%s.data%0d", tag, i), rdy_dat[i], mem_word(i));
      end
      if (i < ov_cyc.size()) begin
        check_eq($sformatf("%s.ov_cyc%0d", tag, i), word_t'(ov_cyc[i]),
                 word_t'(e + 1 + int'(PIPE_LAT)));
        check_eq($sformatf("%s.ov_idx%0d", tag, i), word_t'(ov_idx[i]), word_t'(i));
      end
    end
    check_eq({tag, ".done_n"}, word_t'(done_cyc.size()), word_t'(1));
    if (done_cyc.size() > 0)
      check_eq({tag, ".done_cyc"}, word_t'(done_cyc[0]), word_t'(exp_done));
    check_eq({tag, ".busy_first"}, word_t'(busy_first), word_t'(1));
    check_eq({tag, ".busy_n"}, word_t'(busy_n), word_t'(exp_done));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".rd_en"}, word_t'(io_mem_rd_en), '0);
    check_eq({tag, ".rd_addr"}, word_t'(io_mem_rd_addr), '0);
    check_eq({tag, ".ready_in"}, word_t'(io_datapath_ready_in), '0);
    check_eq({tag, ".data_in"}, io_datapath_data_in, '0);
    check_eq({tag, ".out_valid"}, word_t'(io_out_valid), '0);
    check_eq({tag, ".out_index"}, word_t'(io_out_index), '0);
    check_eq({tag, ".busy"}, word_t'(io_busy), '0);
    check_eq({tag, ".done"}, word_t'(io_done), '0);
  endtask

  initial begin
    reset = 1'b1;
    io_start = 1'b0;
    io_num_cols = '0;
    io_stall = 1'b0;
    io_mem_rd_data = '0;
    clear_log();
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Basic sweep.
    start_sweep(6);
    wait_rel(21);
    check_sweep("basic", 6, 99, 0, 16);
    // rd_data still holds word 5, but ready_in is low.
    check_eq("basic.data_gated", io_datapath_data_in, '0);

    // Stall suppresses the reads of cycles 3 and 4 (held across the edges opening them).
    start_sweep(6);
    wait_rel(2);
    io_stall = 1'b1;
    wait_rel(4);
    io_stall = 1'b0;
    wait_rel(22);
    check_sweep("stall", 6, 2, 2, 18);

    // Zero columns.
    start_sweep(0);
    wait_rel(6);
    check_eq("zero.rd_n", word_t'(rd_cyc.size()), '0);
    check_eq("zero.ov_n", word_t'(ov_cyc.size()), '0);
    check_eq("zero.done_n", word_t'(done_cyc.size()), word_t'(1));
    if (done_cyc.size() > 0) check_eq("zero.done_cyc", word_t'(done_cyc[0]), word_t'(1));
    check_eq("zero.busy_n", word_t'(busy_n), word_t'(1));
    check_eq("zero.busy_first", word_t'(busy_first), word_t'(1));

    // Start while busy is ignored; a start in cycle 17 is accepted.
    start_sweep(6);
    wait_rel(5);
    io_start = 1'b1;
    io_num_cols = (AW + 1)'(3);
    @(negedge clock);
    io_start = 1'b0;
    wait_rel(17);
    check_sweep("busy", 6, 99, 0, 16);
    c_prev = c0;
    start_sweep(4);
    wait_rel(18);
    check_sweep("restart", 4, 99, 0, 14);
    if (rd_cyc.size() > 0)
      check_eq("restart.first_rd", word_t'(c0 - c_prev + rd_cyc[0]), word_t'(18));

    // Asynchronous reset mid-sweep.
    start_sweep(6);
    wait_rel(9);
    #1 reset = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clock);
    reset = 1'b0;
    clear_log();
    repeat (20) @(negedge clock);
    check_eq("midrst.ov_n", word_t'(ov_cyc.size()), '0);
    check_eq("midrst.done_n", word_t'(done_cyc.size()), '0);
    start_sweep(6);
    wait_rel(21);
    check_sweep("postrst", 6, 99, 0, 16);

    // Count above MAX_COLS is clamped.
    start_sweep(100);
    wait_rel(80);
    check_sweep("clamp", 64, 999, 0, 74);
    if (ov_idx.size() > 0)
      check_eq("clamp.last_idx", word_t'(ov_idx[ov_idx.size() - 1]), word_t'(63));

    logging = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
